// File: rtl/align_shift_seq_if.sv
// Handshake bundle for the alignment shifter.
// Operand request side and aligned-result side, with valid/ready on each.
interface align_shift_seq_if #(
  parameter int MANT_W = 24
);
  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] mant_in;
  logic [7:0]        shift_amt;
  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] mant_out;
  logic              guard_out;
  logic              round_out;
  logic              sticky_out;

  // Shifter side: consumes operands, produces aligned results.
  modport slave (
    input  in_valid, mant_in, shift_amt, out_ready,
    output in_ready, out_valid, mant_out, guard_out, round_out, sticky_out
  );

  // Exponent-compare / adder side.
  modport master (
    output in_valid, mant_in, shift_amt, out_ready,
    input  in_ready, out_valid, mant_out, guard_out, round_out, sticky_out
  );
endinterface

// File: rtl/align_shift_seq.sv
// Iterative mantissa alignment shifter, up to STEP positions per clock,
// producing the aligned mantissa with guard, round and sticky bits.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// SHIFT | one shift step of min(rem, STEP) per cycle
// DONE  | result held on the outputs until out_ready
module align_shift_seq #(
  parameter int MANT_W = 24,
  parameter int STEP   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  align_shift_seq_if.slave   bus
);

  localparam int           W_W     = MANT_W + 2;
  localparam logic [4:0]   REM_MAX = 5'(MANT_W + 2);
  localparam logic [4:0]   STEP_K  = 5'(STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [W_W-1:0]   w_q;
  logic             s_q;
  logic [4:0]       rem_q;
  logic             out_valid_q;
  logic             in_ready_q;

  logic [4:0]       amt_clamp_d;
  logic [4:0]       k_d;
  logic [W_W-1:0]   mask_d;
  logic [W_W-1:0]   w_shift_d;
  logic             sticky_add_d;

  always_comb begin
    amt_clamp_d  = (bus.shift_amt >= 8'(REM_MAX)) ? REM_MAX : bus.shift_amt[4:0];
    k_d          = (rem_q < STEP_K) ? rem_q : STEP_K;
    // Bits falling off the bottom this step are the ones below position k.
    mask_d       = ~({W_W{1'b1}} << k_d);
    w_shift_d    = w_q >> k_d;
    sticky_add_d = |(w_q & mask_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      w_q         <= '0;
      s_q         <= 1'b0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // in_ready_q stays low for the first cycle after reset release.
          if (bus.in_valid && in_ready_q) begin
            w_q        <= {bus.mant_in, 2'b00};
            s_q        <= 1'b0;
            rem_q      <= amt_clamp_d;
            in_ready_q <= 1'b0;
            if (amt_clamp_d == 5'd0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q     <= SHIFT;
            end
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        SHIFT: begin
          w_q   <= w_shift_d;
          s_q   <= s_q | sticky_add_d;
          rem_q <= rem_q - k_d;
          if (rem_q == k_d) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.mant_out   = w_q[W_W-1:2];
  assign bus.guard_out  = w_q[1];
  assign bus.round_out  = w_q[0];
  assign bus.sticky_out = s_q;

endmodule
